osd_wb_sram_slave: RTL and testbench

- Wishbone B3 registered-feedback slave with an on-chip SRAM array.
- Responds to the Wishbone master driven by the MAM Wishbone bridge.
- Used as the debug-accessible memory in subsystem testbenches and small SoCs.
- Supports classic cycles, incrementing bursts with linear/wrap-4/8/16 addressing, and byte selects.

---
 rtl/osd_wb_sram_slave.sv | 161 ++++++++++++++++
 tb/tb_osd_wb_sram_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_wb_sram_slave.sv
// Wishbone B3 registered-feedback slave backed by an on-chip SRAM (classic, linear/wrap bursts, byte selects).
// Optional: define OSD_WB_SLAVE_ERR_EN to add err_o for requests outside [BASE_ADDR, BASE_ADDR+MEM_SIZE).
module osd_wb_sram_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
`ifdef OSD_WB_SLAVE_ERR_EN
    output logic                    err_o,
`endif
    output logic [DATA_WIDTH-1:0]   dat_o
);
    localparam int SW      = DATA_WIDTH / 8;
    localparam int OFF_W   = $clog2(SW);
    localparam int LOG_MEM = $clog2(MEM_SIZE);
    localparam int IDX_W   = LOG_MEM - OFF_W;
    localparam int DEPTH   = MEM_SIZE / SW;

    typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   rel_addr;
    logic [IDX_W-1:0]        req_idx, wrap_mask, idx_inc, next_idx;
    logic                    req, beat, wr_en, req_oob, next_oob;
    logic                    unused_bits;

    assign rel_addr    = addr_i - BASE_ADDR;
    assign req_idx     = rel_addr[LOG_MEM-1:OFF_W];
    assign unused_bits = ^rel_addr;

    assign req   = cyc_i & stb_i;
    assign beat  = req & ack_q;
    assign wr_en = beat & we_i;
    assign ack_o = beat;
    assign dat_o = dat_q;

`ifdef OSD_WB_SLAVE_ERR_EN
    localparam logic [ADDR_WIDTH:0] MEM_SIZE_W = (ADDR_WIDTH+1)'(MEM_SIZE);
    logic err_q, err_d;

    assign req_oob  = {1'b0, rel_addr} >= MEM_SIZE_W;
    // Only a linear burst can walk off the top; wrap bursts stay inside their aligned block.
    assign next_oob = (bte_i == 2'b00) && (idx_q == '1);
    assign err_d    = ((state_q == S_IDLE) && req && req_oob) ||
                      ((state_q == S_BURST) && beat && (cti_i == 3'b010) && next_oob);
    assign err_o    = err_q & cyc_i & stb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign req_oob  = 1'b0;
    assign next_oob = 1'b0;
`endif

    // Wrap bursts keep the upper index bits and cycle the low log2(N) bits.
    always_comb begin
        case (bte_i)
            2'b01:   wrap_mask = IDX_W'(3);
            2'b10:   wrap_mask = IDX_W'(7);
            2'b11:   wrap_mask = IDX_W'(15);
            default: wrap_mask = '1;
        endcase
        idx_inc  = idx_q + IDX_W'(1);
        next_idx = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (req) begin
                    idx_d = req_idx;
                    if (req_oob) begin
                        dat_d   = '0;
                        state_d = S_CLASSIC;
                    end else begin
                        dat_d   = mem[req_idx];
                        ack_d   = 1'b1;
                        state_d = (cti_i == 3'b010) ? S_BURST : S_CLASSIC;
                    end
                end
            end
            S_CLASSIC: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_BURST: begin
                if (!cyc_i) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (beat) begin
                    if (cti_i != 3'b010) begin
                        ack_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (next_oob) begin
                        ack_d   = 1'b0;
                        dat_d   = '0;
                        state_d = S_CLASSIC;
                    end else begin
                        idx_d = next_idx;
                        dat_d = mem[next_idx];
                    end
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive a bus reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < SW; i++) begin
            if (wr_en && sel_i[i]) begin
                mem[idx_q][i*8 +: 8] <= dat_i[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_osd_wb_sram_slave.sv
// Directed bench for osd_wb_sram_slave: classic, byte lanes, bursts, wait/abort, reset and address window.
// Build with OSD_WB_SLAVE_ERR_EN defined to exercise err_o instead of aliasing.
module tb_osd_wb_sram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] dat  = '0;
    logic [3:0]  sel  = '0;
    logic [2:0]  cti  = '0;
    logic [1:0]  bte  = '0;
    logic        ack_o;
    logic [31:0] dat_o;
`ifdef OSD_WB_SLAVE_ERR_EN
    logic        err_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    osd_wb_sram_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(4096), .BASE_ADDR(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .addr_i(addr), .dat_i(dat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
        .ack_o(ack_o),
`ifdef OSD_WB_SLAVE_ERR_EN
        .err_o(err_o),
`endif
        .dat_o(dat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One classic cycle; lat = clock cycles between request and ack_o.
    task automatic classic(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = wr; addr = a; dat = d; sel = s; cti = 3'b000; bte = 2'b00;
        lat = 0;
        @(negedge clk);
        while (ack_o !== 1'b1 && lat < 8) begin
            lat++;
            @(negedge clk);
        end
        rd = dat_o;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("classic %s addr=%h wdata=%h sel=%b -> rdata=%h lat=%0d",
                 wr ? "WR" : "RD", a, d, s, rd, lat);
    endtask

    task automatic test_reset;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
        vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_dat: got %h expected 00000000", dat_o); end
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_ack: got %b expected 0", ack_o); end
        vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL post_reset_dat: got %h expected 00000000", dat_o); end
        $display("reset released");
    endtask

    task automatic test_classic;
        logic [31:0] rd; int lat;
        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL classic_wr_lat: got %0d expected 1", lat); end
        classic(1'b0, 32'h10, 32'h0, 4'hF, rd, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL classic_rd_lat: got %0d expected 1", lat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL classic_rd: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd; int lat;
        classic(1'b1, 32'h20, 32'h11223344, 4'hF, rd, lat);
        classic(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat);
        classic(1'b0, 32'h20, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'h11BB33DD) begin miscompares++; $display("FAIL lanes_0101: got %h expected 11bb33dd", rd); end
        classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL sel0_ack_lat: got %0d expected 1", lat); end
        classic(1'b0, 32'h20, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'h11BB33DD) begin miscompares++; $display("FAIL sel0_nowrite: got %h expected 11bb33dd", rd); end
    endtask

    // Strobe held across two classic transfers: ack_o must alternate 0,1,0,1.
    task automatic test_back_to_back;
        logic exp_ack [4];
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h20; cti = 3'b000; bte = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (ack_o !== exp_ack[k]) begin miscompares++; $display("FAIL b2b_ack[%0d]: got %b expected %b", k, ack_o, exp_ack[k]); end
        end
        vectors++; if (dat_o !== 32'h11BB33DD) begin miscompares++; $display("FAIL b2b_dat: got %h expected 11bb33dd", dat_o); end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        $display("back_to_back classic reads at 0x20 done");
    endtask

    task automatic burst_read(input string name, input logic [1:0] b,
                              input logic [31:0] a [4], input logic [31:0] e [4]);
        int lat;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; bte = b;
        for (int k = 0; k < 4; k++) begin
            addr = a[k];
            cti  = (k == 3) ? 3'b111 : 3'b010;
            if (k == 0) begin
                lat = 0;
                @(negedge clk);
                while (ack_o !== 1'b1 && lat < 8) begin
                    lat++;
                    @(negedge clk);
                end
                vectors++; if (lat !== 1) begin miscompares++; $display("FAIL %s_lat: got %0d expected 1", name, lat); end
            end else begin
                @(negedge clk);
            end
            vectors++; if (ack_o !== 1'b1) begin miscompares++; $display("FAIL %s_ack[%0d]: got %b expected 1", name, k, ack_o); end
            vectors++; if (dat_o !== e[k]) begin miscompares++; $display("FAIL %s_dat[%0d]: got %h expected %h", name, k, dat_o, e[k]); end
            $display("burst %s beat %0d addr=%h rdata=%h", name, k, a[k], dat_o);
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL %s_end_ack: got %b expected 0", name, ack_o); end
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    endtask

    task automatic test_bursts;
        logic [31:0] rd; int lat;
        logic [31:0] a [4];
        logic [31:0] e [4];
        for (int k = 0; k < 4; k++) classic(1'b1, 32'h100 + 32'(4*k), 32'(k + 1), 4'hF, rd, lat);
        a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        e = '{32'd1, 32'd2, 32'd3, 32'd4};
        burst_read("linear", 2'b00, a, e);
        a = '{32'h108, 32'h10C, 32'h100, 32'h104};
        e = '{32'd3, 32'd4, 32'd1, 32'd2};
        burst_read("wrap4", 2'b01, a, e);
    endtask

    task automatic test_wait_state;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (ack_o !== 1'b1 || dat_o !== 32'd1) begin miscompares++; $display("FAIL wait_beat0: got ack=%b dat=%h expected ack=1 dat=00000001", ack_o, dat_o); end
        @(posedge clk); #1;
        stb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL wait_ack[%0d]: got %b expected 0", k, ack_o); end
            vectors++; if (dat_o !== 32'd2) begin miscompares++; $display("FAIL wait_hold[%0d]: got %h expected 00000002", k, dat_o); end
            @(posedge clk); #1;
        end
        stb = 1'b1; addr = 32'h104; cti = 3'b010;
        @(negedge clk);
        vectors++; if (ack_o !== 1'b1 || dat_o !== 32'd2) begin miscompares++; $display("FAIL wait_resume1: got ack=%b dat=%h expected ack=1 dat=00000002", ack_o, dat_o); end
        @(posedge clk); #1;
        addr = 32'h108; cti = 3'b111;
        @(negedge clk);
        vectors++; if (ack_o !== 1'b1 || dat_o !== 32'd3) begin miscompares++; $display("FAIL wait_resume2: got ack=%b dat=%h expected ack=1 dat=00000003", ack_o, dat_o); end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        $display("wait-state burst done");
    endtask

    task automatic test_abort;
        logic [31:0] rd; int lat;
        for (int k = 0; k < 4; k++) classic(1'b1, 32'h200 + 32'(4*k), 32'hA0 + 32'(k), 4'hF, rd, lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h200; dat = 32'h55; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (ack_o !== 1'b1) begin miscompares++; $display("FAIL abort_beat0_ack: got %b expected 1", ack_o); end
        @(posedge clk); #1;
        addr = 32'h204; dat = 32'h66;
        @(negedge clk);
        vectors++; if (ack_o !== 1'b1) begin miscompares++; $display("FAIL abort_beat1_ack: got %b expected 1", ack_o); end
        @(posedge clk); #1;
        cyc = 1'b0; addr = 32'h208; dat = 32'h77;
        @(negedge clk);
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL abort_ack: got %b expected 0", ack_o); end
        stb = 1'b0; we = 1'b0;
        classic(1'b0, 32'h200, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'h55) begin miscompares++; $display("FAIL abort_w0: got %h expected 00000055", rd); end
        classic(1'b0, 32'h204, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'h66) begin miscompares++; $display("FAIL abort_w1: got %h expected 00000066", rd); end
        classic(1'b0, 32'h208, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'hA2) begin miscompares++; $display("FAIL abort_nowrite: got %h expected 000000a2", rd); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL abort_idle_lat: got %0d expected 1", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int lat;
        classic(1'b1, 32'h30, 32'h12345678, 4'hF, rd, lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h30; cti = 3'b000;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (ack_o !== 1'b1 || dat_o !== 32'h12345678) begin miscompares++; $display("FAIL rstmid_pre: got ack=%b dat=%h expected ack=1 dat=12345678", ack_o, dat_o); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_ack: got %b expected 0", ack_o); end
        vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_dat: got %h expected 00000000", dat_o); end
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        classic(1'b0, 32'h30, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("FAIL rstmid_retain: got %h expected 12345678", rd); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; int lat;
        classic(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, lat);
`ifdef OSD_WB_SLAVE_ERR_EN
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h1000; dat = 32'h0BAD0BAD; sel = 4'hF; cti = 3'b000;
        @(negedge clk);
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL oob_err_early: got %b expected 0", err_o); end
        @(negedge clk);
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL oob_err: got %b expected 1", err_o); end
        vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL oob_ack: got %b expected 0", ack_o); end
        vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL oob_dat: got %h expected 00000000", dat_o); end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL oob_err_clear: got %b expected 0", err_o); end
        classic(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL oob_mem_kept: got %h expected cafef00d", rd); end
`else
        classic(1'b0, 32'h1000, 32'h0, 4'hF, rd, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL alias_lat: got %0d expected 1", lat); end
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL alias_rd: got %h expected cafef00d", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_classic();
        test_byte_lanes();
        test_back_to_back();
        test_bursts();
        test_wait_state();
        test_abort();
        test_reset_mid();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
